// File: rtl/vgacon_term_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vgacon_term_ctrl_if
// Description : Character stream, host write and text-buffer port bundle
//               for the VGA console terminal sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vgacon_term_ctrl_if #(
  parameter int ADDR_W = 5
);
  // character byte stream (valid/ready)
  logic              ch_valid;
  logic [7:0]        ch_data;
  logic              ch_ready;
  // direct host write, always wins the buffer write port
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  // text buffer port (read is combinational, same cycle)
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]        buf_rdata;

  // environment side: feeds characters/host writes and models the buffer
  modport master (
    output ch_valid, ch_data, host_we, host_addr, host_wdata, buf_rdata,
    input  ch_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
  );

  // controller side
  modport slave (
    input  ch_valid, ch_data, host_we, host_addr, host_wdata, buf_rdata,
    output ch_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
  );
endinterface
`default_nettype wire

// File: rtl/vgacon_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vgacon_term_ctrl
// Description : Terminal-style sequencer for the VGA console text buffer.
//               Accepts character bytes, keeps a cursor, interprets CR/LF/
//               BS/FF, and runs scroll-up and clear-all sweeps over the
//               buffer. Host writes always take the write port first.
// Revision    : 1.0 - initial release
// ============================================================================
module vgacon_term_ctrl #(
  parameter int         NUM_ROWS         = 3,
  parameter int         NUM_COLS         = 10,
  parameter int         ADDR_W           = $clog2(NUM_ROWS*NUM_COLS),
  parameter logic [7:0] FILL_CHAR        = 8'h20,
  parameter bit         SCROLL_IN_VBLANK = 1'b1
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  vgacon_term_ctrl_if.slave                bus,
  input  wire logic                        vblank,
  output logic [$clog2(NUM_COLS)-1:0]      cursor_col,
  output logic [$clog2(NUM_ROWS)-1:0]      cursor_row,
  output logic                             busy
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = $clog2(NUM_ROWS);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(NUM_COLS);
  // last destination cell of the copy phase; the fill phase starts right after
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(NUM_COLS*(NUM_ROWS-1) - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(NUM_COLS*NUM_ROWS - 1);

  localparam logic [6:0] CODE_BS = 7'h08;
  localparam logic [6:0] CODE_LF = 7'h0A;
  localparam logic [6:0] CODE_FF = 7'h0C;
  localparam logic [6:0] CODE_CR = 7'h0D;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PUT         = 3'd1,
    WAIT_VBL    = 3'd2,
    SCROLL_COPY = 3'd3,
    SCROLL_FILL = 3'd4,
    CLEAR_ALL   = 3'd5
  } state_t;

  state_t             state;
  logic [7:0]         ch_byte;    // byte latched at the handshake
  logic [ADDR_W-1:0]  cnt;        // sweep cell index for scroll/clear
  logic               op_clear;   // what WAIT_VBL launches: 1 = clear-all

  logic [6:0]         code;
  logic               is_print;
  logic               col_last;
  logic               row_last;
  logic               need_wait;
  logic [ADDR_W-1:0]  cur_idx;

  logic               eng_we;
  logic [ADDR_W-1:0]  eng_waddr;
  logic [7:0]         eng_wdata;
  logic [ADDR_W-1:0]  eng_raddr;
  logic               stall;

  assign code      = ch_byte[6:0];
  assign is_print  = (code >= 7'h20) && (code <= 7'h7E);
  assign col_last  = (cursor_col == LAST_COL);
  assign row_last  = (cursor_row == LAST_ROW);
  assign need_wait = SCROLL_IN_VBLANK & ~vblank;
  assign cur_idx   = ADDR_W'(cursor_row) * ROW_STEP + ADDR_W'(cursor_col);

  // status outputs follow the registered state directly
  assign bus.ch_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // engine write request and read address for the current state
  always_comb begin
    eng_we    = 1'b0;
    eng_waddr = '0;
    eng_wdata = FILL_CHAR;
    eng_raddr = '0;
    case (state)
      PUT: begin
        if (is_print) begin
          eng_we    = 1'b1;
          eng_waddr = cur_idx;
          eng_wdata = ch_byte;
        end else if (code == CODE_BS && cursor_col != '0) begin
          eng_we    = 1'b1;
          eng_waddr = cur_idx - 1'b1;
          eng_wdata = FILL_CHAR;
        end
      end
      SCROLL_COPY: begin
        eng_we    = 1'b1;
        eng_waddr = cnt;
        eng_raddr = cnt + ROW_STEP;
        eng_wdata = bus.buf_rdata;
      end
      SCROLL_FILL, CLEAR_ALL: begin
        eng_we    = 1'b1;
        eng_waddr = cnt;
        eng_wdata = FILL_CHAR;
      end
      default: begin
        eng_we = 1'b0;
      end
    endcase
  end

  // host priority: a host write takes the port and freezes a writing engine
  always_comb begin
    stall         = bus.host_we & eng_we;
    bus.buf_we    = bus.host_we | eng_we;
    bus.buf_waddr = bus.host_we ? bus.host_addr  : eng_waddr;
    bus.buf_wdata = bus.host_we ? bus.host_wdata : eng_wdata;
    bus.buf_raddr = eng_raddr;
  end

  // sequencer: handshake, code decode, cursor and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch_byte    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      cnt        <= '0;
      op_clear   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ch_valid) begin
            ch_byte <= bus.ch_data;
            state   <= PUT;
          end
        end

        PUT: begin
          if (!stall) begin
            state <= IDLE;
            if (is_print) begin
              if (col_last) begin
                cursor_col <= '0;
                if (row_last) begin
                  // bottom row full: cursor stays on the last row, scroll up
                  op_clear <= 1'b0;
                  cnt      <= '0;
                  state    <= need_wait ? WAIT_VBL : SCROLL_COPY;
                end else begin
                  cursor_row <= cursor_row + ROW_W'(1);
                end
              end else begin
                cursor_col <= cursor_col + COL_W'(1);
              end
            end else begin
              case (code)
                CODE_CR: cursor_col <= '0;
                CODE_LF: begin
                  cursor_col <= '0;
                  if (row_last) begin
                    op_clear <= 1'b0;
                    cnt      <= '0;
                    state    <= need_wait ? WAIT_VBL : SCROLL_COPY;
                  end else begin
                    cursor_row <= cursor_row + ROW_W'(1);
                  end
                end
                CODE_BS: begin
                  if (cursor_col != '0) begin
                    cursor_col <= cursor_col - COL_W'(1);
                  end
                end
                CODE_FF: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  op_clear   <= 1'b1;
                  cnt        <= '0;
                  state      <= need_wait ? WAIT_VBL : CLEAR_ALL;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end

        WAIT_VBL: begin
          if (vblank) begin
            state <= op_clear ? CLEAR_ALL : SCROLL_COPY;
          end
        end

        SCROLL_COPY: begin
          if (!stall) begin
            cnt <= cnt + 1'b1;
            if (cnt == COPY_LAST) begin
              state <= SCROLL_FILL;
            end
          end
        end

        SCROLL_FILL, CLEAR_ALL: begin
          if (!stall) begin
            if (cnt == CELL_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vgacon_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vgacon_term_ctrl
// Description : Self-checking bench for vgacon_term_ctrl. Keeps a screen
//               model plus a queue of expected engine writes derived from
//               terminal rules, and checks every buffer write as it occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vgacon_term_ctrl;

  localparam int NR = 3;
  localparam int NC = 10;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vblank;
  logic [3:0]    cursor_col;
  logic [1:0]    cursor_row;
  logic          busy;

  vgacon_term_ctrl_if #(.ADDR_W(AW)) bus ();

  vgacon_term_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .vblank     (vblank),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // text buffer: synchronous write, combinational read
  logic [7:0] mem [0:31];
  assign bus.buf_rdata = mem[bus.buf_raddr];

  initial begin : buffer_model
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    forever begin
      @(posedge clk);
      if (bus.buf_we) mem[bus.buf_waddr] <= bus.buf_wdata;
    end
  end

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic       copy;   // 1: destination gets the cell one row below
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] scr [0:31];
  int         mrow, mcol;
  int         tests, fails;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    exp_t e;
    e.copy = 1'b0; e.addr = 8'(a); e.data = d;
    expq.push_back(e);
  endtask

  task automatic push_scroll();
    exp_t e;
    for (int i = 0; i < NC*(NR-1); i++) begin
      e.copy = 1'b1; e.addr = 8'(i); e.data = 8'h00;
      expq.push_back(e);
    end
    for (int i = NC*(NR-1); i < NC*NR; i++) push_wr(i, 8'h20);
  endtask

  task automatic new_line();
    if (mrow == NR-1) push_scroll();
    else mrow++;
  endtask

  // terminal rules applied to the model cursor and expected-write queue
  task automatic model_char(input logic [7:0] b);
    logic [6:0] c;
    c = b[6:0];
    if (c >= 7'h20 && c <= 7'h7E) begin
      push_wr(mrow*NC + mcol, b);
      mcol++;
      if (mcol == NC) begin
        mcol = 0;
        new_line();
      end
    end else if (c == 7'h0D) begin
      mcol = 0;
    end else if (c == 7'h0A) begin
      mcol = 0;
      new_line();
    end else if (c == 7'h08) begin
      if (mcol > 0) begin
        mcol--;
        push_wr(mrow*NC + mcol, 8'h20);
      end
    end else if (c == 7'h0C) begin
      mrow = 0;
      mcol = 0;
      for (int i = 0; i < NR*NC; i++) push_wr(i, 8'h20);
    end
  endtask

  // per-cycle checker of every buffer write against the model
  initial begin : compare
    exp_t e;
    int   ea, ed;
    for (int i = 0; i < 32; i++) scr[i] = 8'(i);
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("ready_eq_not_busy", int'(bus.ch_ready), int'(!busy));
        if (bus.host_we) begin
          chk("host_grant_we", int'(bus.buf_we), 1);
          chk("host_grant_addr", int'(bus.buf_waddr), int'(bus.host_addr));
          chk("host_grant_data", int'(bus.buf_wdata), int'(bus.host_wdata));
          scr[bus.host_addr] = bus.host_wdata;
        end else if (bus.buf_we) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0d data %02h, required no write (t=%0t)",
                     bus.buf_waddr, bus.buf_wdata, $time);
          end else begin
            e  = expq.pop_front();
            ea = int'(e.addr);
            ed = e.copy ? int'(scr[ea+NC]) : int'(e.data);
            chk("write_addr", int'(bus.buf_waddr), ea);
            chk("write_data", int'(bus.buf_wdata), ed);
            scr[ea] = 8'(ed);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // tasks start and end at a falling clock edge
  task automatic send_char(input logic [7:0] b);
    int k;
    k = 0;
    #1;
    while (!bus.ch_ready && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.ch_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ch_ready stayed 0, required 1");
    end
    model_char(b);
    bus.ch_valid = 1'b1;
    bus.ch_data  = b;
    @(negedge clk);
    bus.ch_valid = 1'b0;
  endtask

  // counts busy cycles from the current edge until the controller is idle
  task automatic wait_idle(output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      #1;
      if (!busy) done = 1'b1;
      else n++;
      @(negedge clk);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy stayed 1, required 0");
    end
    chk("expected_writes_left", expq.size(), 0);
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_row"}, int'(cursor_row), mrow);
    chk({tag, "_col"}, int'(cursor_col), mcol);
  endtask

  task automatic check_screen();
    for (int i = 0; i < NR*NC; i++)
      chk($sformatf("screen_cell%0d", i), int'(mem[i]), int'(scr[i]));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n, nb, nw;
    tests = 0; fails = 0; mrow = 0; mcol = 0;
    rst_n = 1'b0; vblank = 1'b1;
    bus.ch_valid = 1'b0; bus.ch_data = 8'h00;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(bus.ch_ready), 1);
    chk("reset_buf_we", int'(bus.buf_we), 0);
    chk("reset_row", int'(cursor_row), 0);
    chk("reset_col", int'(cursor_col), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 'A' then 'B' with ch_valid held: ready toggles 1,0,1,0
    model_char(8'h41);
    model_char(8'h42);
    bus.ch_valid = 1'b1; bus.ch_data = 8'h41;
    #1; chk("ready_pat0", int'(bus.ch_ready), 1);
    @(negedge clk); bus.ch_data = 8'h42;
    #1; chk("ready_pat1", int'(bus.ch_ready), 0);
    @(negedge clk);
    #1; chk("ready_pat2", int'(bus.ch_ready), 1);
    @(negedge clk);
    #1; chk("ready_pat3", int'(bus.ch_ready), 0);
    bus.ch_valid = 1'b0;
    @(negedge clk);
    wait_idle(n);
    chk("idx0_A", int'(mem[0]), 8'h41);
    chk("idx1_B", int'(mem[1]), 8'h42);
    chk("ab_row", int'(cursor_row), 0);
    chk("ab_col", int'(cursor_col), 2);

    // finish row 0 and wrap; colored char lands at the start of row 1
    for (int i = 0; i < 8; i++) send_char(8'(8'h30 + i));
    send_char(8'hC1);
    wait_idle(n);
    chk("idx9_last", int'(mem[9]), 8'h37);
    chk("idx10_color", int'(mem[10]), 8'hC1);
    chk("wrap_row", int'(cursor_row), 1);
    chk("wrap_col", int'(cursor_col), 1);

    // CR, BS at column 0, then BS at column 4, then an ignored code
    send_char(8'h0D);
    send_char(8'h08);
    wait_idle(n);
    chk("bs0_row", int'(cursor_row), 1);
    chk("bs0_col", int'(cursor_col), 0);
    send_char(8'h77); send_char(8'h78); send_char(8'h79); send_char(8'h7A);
    send_char(8'h08);
    wait_idle(n);
    chk("bs4_cell13", int'(mem[13]), 8'h20);
    chk("bs4_cell12", int'(mem[12]), 8'h79);
    chk("bs4_col", int'(cursor_col), 3);
    send_char(8'h07);
    wait_idle(n);
    check_cursor("bel");

    // form feed: 30 fill writes, cursor home
    send_char(8'h0C);
    wait_idle(n);
    chk("ff_busy_cycles", n, 31);
    chk("ff_row", int'(cursor_row), 0);
    chk("ff_col", int'(cursor_col), 0);
    chk("ff_cell29", int'(mem[29]), 8'h20);
    check_screen();

    // three rows of text, then LF on the bottom row while not in vblank
    send_char(8'h48); send_char(8'h49); send_char(8'h0A);
    send_char(8'h4A); send_char(8'h4B); send_char(8'h4C); send_char(8'h0A);
    for (int i = 0; i < 5; i++) send_char(8'(8'h4D + i));
    wait_idle(n);
    vblank = 1'b0;
    send_char(8'h0A);
    nb = 0; nw = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (!busy) nb++;
      if (bus.buf_we) nw++;
      @(negedge clk);
    end
    chk("vbl_wait_not_busy", nb, 0);
    chk("vbl_wait_writes", nw, 0);
    vblank = 1'b1;
    wait_idle(n);
    chk("vbl_scroll_cycles", n, 31);
    chk("scroll_cell0", int'(mem[0]), 8'h4A);
    chk("scroll_cell10", int'(mem[10]), 8'h4D);
    chk("scroll_cell14", int'(mem[14]), 8'h51);
    chk("scroll_cell20", int'(mem[20]), 8'h20);
    chk("scroll_row", int'(cursor_row), 2);
    chk("scroll_col", int'(cursor_col), 0);
    check_screen();

    // host writes to cell 29 during the copy phase stall the sweep 3 cycles
    send_char(8'h0A);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      bus.host_we    = (k >= 3 && k <= 5);
      bus.host_addr  = 5'd29;
      bus.host_wdata = 8'h55;
      #1;
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    bus.host_we = 1'b0;
    @(negedge clk);
    chk("host_busy_cycles", n, 34);
    chk("host_cell29", int'(mem[29]), 8'h20);
    chk("host_cell19", int'(mem[19]), 8'h55);
    chk("host_left", expq.size(), 0);
    check_cursor("host");
    check_screen();

    // asynchronous reset part-way through a scroll
    send_char(8'h0A);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(bus.ch_ready), 1);
    chk("arst_row", int'(cursor_row), 0);
    chk("arst_col", int'(cursor_col), 0);
    expq.delete();
    mrow = 0; mcol = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("arst_no_write", int'(bus.buf_we), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_screen();
    send_char(8'h5A);
    wait_idle(n);
    chk("post_rst_cell0", int'(mem[0]), 8'h5A);
    chk("post_rst_col", int'(cursor_col), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vgacon_term_ctrl.md
Name: vgacon_term_ctrl

Overview:
Terminal-style sequencer for the VGA console text buffer. It accepts a stream of character bytes over a valid/ready handshake and maintains a cursor. It interprets a small set of control codes and issues single-cell writes into the text buffer. It performs scroll-up and clear operations by sequencing buffer read/write cycles, optionally deferred to vertical blanking, and shares the buffer write port with direct host writes, which always have priority.

Parameters:
NUM_ROWS, 3, text rows in buffer
NUM_COLS, 10, text columns per row
ADDR_W, $clog2(NUM_ROWS*NUM_COLS), buffer address width (5 at defaults)
FILL_CHAR, 8'h20, byte written to cleared cells (color bit 0)
SCROLL_IN_VBLANK, 1, 1 = scroll/clear-all start only while vblank=1

Ports:
clk  in  1  project clock
rst_n  in  1  reset, asynchronous, active-low
ch_valid  in  1  character byte offered
ch_data  in  8  {color_sel, 7-bit code}
ch_ready  out  1  controller accepts ch_data this cycle
host_we  in  1  direct host write to buffer (priority)
host_addr  in  ADDR_W  host write cell index
host_wdata  in  8  host write byte
vblank  in  1  vertical blanking from VGA timing (vsync region)
buf_we  out  1  text buffer write enable
buf_waddr  out  ADDR_W  text buffer write index
buf_wdata  out  8  text buffer write data
buf_raddr  out  ADDR_W  text buffer read index (combinational read)
buf_rdata  in  8  text buffer data at buf_raddr, same cycle
cursor_col  out  $clog2(NUM_COLS)  current column
cursor_row  out  $clog2(NUM_ROWS)  current row
busy  out  1  state != IDLE

Behaviour:
- Cell index = row*NUM_COLS + col.
- States: IDLE, PUT, WAIT_VBL, SCROLL_COPY, SCROLL_FILL, CLEAR_ALL.
- Reset: state IDLE, cursor (0,0), counters 0. Outputs at reset: ch_ready=1, buf_we=host_we, busy=0. No buffer contents are cleared.
- ch_ready = (state==IDLE). A transfer occurs on ch_valid & ch_ready at cycle T. The byte is latched and the state goes to PUT at T+1.
- PUT decodes the latched byte on bits [6:0]:
  - 0x20-0x7E: write the byte (with its color bit) at the cursor, then col+1.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: col=0, row+1, no write.
  - 0x08 BS: if col>0, col-1 and write FILL_CHAR at the new cell; at col 0, no-op.
  - 0x0C FF: go to CLEAR_ALL (or WAIT_VBL), cursor (0,0).
  - Any other code: ignored, return to IDLE.
- Wrap: when col would reach NUM_COLS, col=0 and row+1.
- Row overflow (row+1 == NUM_ROWS from printable char or LF): row stays NUM_ROWS-1, col=0, and a scroll is started.
- Scroll start: if SCROLL_IN_VBLANK and vblank==0, enter WAIT_VBL; leave it on the first cycle with vblank==1. Once started, a scroll or clear-all runs to completion regardless of vblank.
- SCROLL_COPY, counter i = 0..NUM_COLS*(NUM_ROWS-1)-1: buf_raddr=i+NUM_COLS, buf_waddr=i, buf_wdata=buf_rdata, one cell per cycle.
- SCROLL_FILL, i = (NUM_ROWS-1)*NUM_COLS..NUM_ROWS*NUM_COLS-1: write FILL_CHAR.
- CLEAR_ALL, i = 0..NUM_ROWS*NUM_COLS-1: write FILL_CHAR.
- Totals without stalls at defaults: scroll 30 cycles, clear-all 30 cycles. Return to IDLE after the last write.
- Arbitration (combinational):
  - If host_we, then buf_we=1, buf_waddr=host_addr, buf_wdata=host_wdata, and the engine's pending write stalls. The engine's state, counter and cursor hold that cycle.
  - Otherwise buf_we = engine write strobe.
  - A PUT stalled by host_we retries the next cycle.
  - A host write landing in a region not yet processed by a scroll may be overwritten; this is accepted behaviour.
- buf_raddr = 0 when not in SCROLL_COPY.
- Cursor updates occur in the cycle the PUT write is granted, or the PUT cycle for non-writing codes.
- Async reset mid-scroll: immediate return to the reset state. A partially scrolled buffer is left as is.
- Throughput: 1 printable char per 2 cycles when uncontended.

Test Plan:
- Reset, send 'A'(0x41) then 'B' with ch_valid held -> writes idx0=0x41 at T+1, idx1=0x42; cursor (0,2); ch_ready pattern 1,0,1,0.
- 10 chars on row 0, then 0xC1 -> idx9 written, wrap to row 1; 0xC1 written at idx10 with color bit set; cursor (1,1).
- Fill row 2, LF with vblank=0 for 50 cycles then 1 -> busy held and no buffer writes until vblank; then 20 copy writes (idx i <- idx i+10) and 10 FILL writes to idx 20-29; cursor (2,0).
- During SCROLL_COPY pulse host_we 3 cycles to addr 29 with 0x55 -> host writes granted each cycle; copy counter frozen; scroll total 33 cycles; final idx29=0x20.
- BS at col 0 -> no write, cursor unchanged. At col 4 -> write 0x20 at idx3, col 3. FF -> 30 writes of 0x20, cursor (0,0). Code 0x07 -> no write.
- Assert rst_n=0 mid-scroll -> busy=0 and ch_ready=1 immediately; cursor (0,0); no further buffer writes.
